// File: rtl/sort_mem_pkg.sv
// Shared constants for the sort-array memory responder: response codes,
// read FSM state encodings and default widths.
package sort_mem_pkg;

  localparam int ADDR_WDTH_DEF = 4;
  localparam int DATA_WDTH_DEF = 32;
  localparam int RESP_WDTH_DEF = 1;

  localparam int RESP_OKAY   = 0;
  localparam int RESP_SLVERR = 1;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

endpackage

// File: rtl/sort_mem_responder_if.sv
// Read (AR/R) and write (AW/W/B) channels between the sort datapath and the
// memory responder. Every channel follows one rule: a transfer happens on a
// rising edge where valid and ready are both high; a source holds its payload
// stable while valid is high and ready is low.
interface sort_mem_responder_if #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1
);
  logic                 ar_valid;
  logic                 ar_ready;
  logic [ADDR_WDTH-1:0] ar_address;
  logic                 r_valid;
  logic                 r_ready;
  logic [DATA_WDTH-1:0] r_data;
  logic [RESP_WDTH-1:0] r_resp;
  logic                 aw_valid;
  logic                 aw_ready;
  logic [ADDR_WDTH-1:0] write_addr;
  logic                 w_valid;
  logic                 w_ready;
  logic [DATA_WDTH-1:0] write_data;
  logic                 b_valid;
  logic                 b_ready;
  logic [RESP_WDTH-1:0] b_resp;

  modport master (
    output ar_valid, ar_address, r_ready, aw_valid, write_addr,
           w_valid, write_data, b_ready,
    input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready,
           b_valid, b_resp
  );

  modport slave (
    input  ar_valid, ar_address, r_ready, aw_valid, write_addr,
           w_valid, write_data, b_ready,
    output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready,
           b_valid, b_resp
  );
endinterface

// File: rtl/sort_mem_array.sv
// Register-array storage: one asynchronous read port, one synchronous write
// port with enable, whole array cleared by synchronous reset.
module sort_mem_array #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_WDTH-1:0] waddr,
  input  logic [DATA_WDTH-1:0] wdata,
  input  logic [ADDR_WDTH-1:0] raddr,
  output logic [DATA_WDTH-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_WDTH;

  logic [DATA_WDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sort_mem_responder.sv
// Memory responder for the insertion-sort array: single-outstanding reads and
// writes with range checking against arr_size. Define SORT_MEM_WR_FIRST_EN
// for write-first read data on same-cycle same-address collisions.
module sort_mem_responder
  import sort_mem_pkg::*;
#(
  parameter int ADDR_WDTH = ADDR_WDTH_DEF,
  parameter int DATA_WDTH = DATA_WDTH_DEF,
  parameter int RESP_WDTH = RESP_WDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WDTH:0]    arr_size,
  sort_mem_responder_if.slave   bus,
  output rd_state_e             rd_state_dbg
);
  rd_state_e            rd_state;
  logic [DATA_WDTH-1:0] r_data_q;
  logic [RESP_WDTH-1:0] r_resp_q;

  logic                 aw_pending;
  logic [ADDR_WDTH-1:0] aw_addr_q;
  logic                 w_pending;
  logic [DATA_WDTH-1:0] w_data_q;
  logic                 b_valid_q;
  logic [RESP_WDTH-1:0] b_resp_q;

  logic                 ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic                 commit, wr_in_range, rd_in_range, we;
  logic [ADDR_WDTH-1:0] cmt_addr;
  logic [DATA_WDTH-1:0] cmt_data;
  logic [DATA_WDTH-1:0] rd_word, rd_sel;

  assign bus.ar_ready = (rd_state == RD_IDLE);
  assign bus.r_valid  = (rd_state == RD_RESP);
  assign bus.r_data   = r_data_q;
  assign bus.r_resp   = r_resp_q;
  assign bus.aw_ready = !aw_pending && !b_valid_q;
  assign bus.w_ready  = !w_pending && !b_valid_q;
  assign bus.b_valid  = b_valid_q;
  assign bus.b_resp   = b_resp_q;
  assign rd_state_dbg = rd_state;

  assign ar_hs = bus.ar_valid && bus.ar_ready;
  assign r_hs  = bus.r_valid && bus.r_ready;
  assign aw_hs = bus.aw_valid && bus.aw_ready;
  assign w_hs  = bus.w_valid && bus.w_ready;
  assign b_hs  = b_valid_q && bus.b_ready;

  // A held entry takes precedence: its channel cannot handshake while pending.
  assign commit   = (aw_pending || aw_hs) && (w_pending || w_hs);
  assign cmt_addr = aw_pending ? aw_addr_q : bus.write_addr;
  assign cmt_data = w_pending ? w_data_q : bus.write_data;

  assign wr_in_range = {1'b0, cmt_addr} < arr_size;
  assign rd_in_range = {1'b0, bus.ar_address} < arr_size;
  assign we          = commit && wr_in_range;

  sort_mem_array #(
    .ADDR_WDTH(ADDR_WDTH),
    .DATA_WDTH(DATA_WDTH)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr(cmt_addr),
    .wdata(cmt_data),
    .raddr(bus.ar_address),
    .rdata(rd_word)
  );

`ifdef SORT_MEM_WR_FIRST_EN
  assign rd_sel = (we && (cmt_addr == bus.ar_address)) ? cmt_data : rd_word;
`else
  assign rd_sel = rd_word;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      r_data_q <= '0;
      r_resp_q <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: if (ar_hs) begin
          rd_state <= RD_RESP;
          r_data_q <= rd_sel;
          r_resp_q <= rd_in_range ? RESP_WDTH'(RESP_OKAY) : RESP_WDTH'(RESP_SLVERR);
        end
        RD_RESP: if (r_hs) rd_state <= RD_IDLE;
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_pending <= 1'b0;
      aw_addr_q  <= '0;
      w_pending  <= 1'b0;
      w_data_q   <= '0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= '0;
    end else begin
      if (commit) begin
        aw_pending <= 1'b0;
        w_pending  <= 1'b0;
        b_valid_q  <= 1'b1;
        b_resp_q   <= wr_in_range ? RESP_WDTH'(RESP_OKAY) : RESP_WDTH'(RESP_SLVERR);
      end else begin
        if (aw_hs) begin
          aw_pending <= 1'b1;
          aw_addr_q  <= bus.write_addr;
        end
        if (w_hs) begin
          w_pending <= 1'b1;
          w_data_q  <= bus.write_data;
        end
        if (b_hs) b_valid_q <= 1'b0;
      end
    end
  end

endmodule
